// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFOs in this datapath.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package fifo_pkg;

    // Width of a fill-level counter that must represent 0..depth inclusive.
    // For depth=4 this is 3 bits, for depth=32 it is 6 bits.
    function automatic int fifo_lw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Latency: write visible on rd_data the cycle after the write edge.
// Backpressure: none; the caller guarantees addresses stay below FIFO_DEPTH.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(FIFO_DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [$clog2(FIFO_DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]         rd_data
);

    // Contents are deliberately left unreset; validity is tracked by the owner.
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Write port: one entry per edge when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FWFT FIFO, any depth >= 2, optional registered output, level flags, flush, sticky overflow.
// Latency: a write accepted at edge N is presented on m_valid/m_data right after edge N (both modes).
// Backpressure: s_ready = (level != FIFO_DEPTH), independent of m_ready; writes while full are dropped and flagged.
module stream_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 32,
    parameter int OUTPUT_REG   = 0,
    parameter int AFULL_LEVEL  = FIFO_DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [DATA_WIDTH-1:0]            s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [fifo_lw(FIFO_DEPTH)-1:0]   level,
    output logic                             almost_full,
    output logic                             almost_empty,
    output logic                             ovf,
    input  logic                             ovf_clr
);

    localparam int LW = fifo_lw(FIFO_DEPTH);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LEVEL);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LEVEL);
    localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);

    // Explicit wrap so depths that are not a power of two never index past the array.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    logic [LW-1:0]         count;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  mem_we;
    logic                  rd_adv;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // count includes the output register entry when it exists, so empty/full
    // are the same simple compares in both modes.
    assign s_ready      = (count != DEPTH_L);
    assign m_valid      = (count != '0);
    assign wr_fire      = s_valid && s_ready;
    assign rd_fire      = m_valid && m_ready;
    assign level        = count;
    assign almost_full  = (count >= AFULL_L);
    assign almost_empty = (count <= AEMPTY_L);

    // Fill level: up/down counter; simultaneous read and write cancel out.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else if (wr_fire && !rd_fire) begin
            count <= count + LW'(1);
        end else if (!wr_fire && rd_fire) begin
            count <= count - LW'(1);
        end
    end

    // Sticky overflow: a new overflow beats a clear in the same cycle; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (s_valid && !s_ready) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // Write pointer follows storage writes only (bypassed writes skip the array).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
        end else if (mem_we) begin
            wr_ptr <= ptr_inc(wr_ptr);
        end
    end

    // Read pointer advances whenever an entry leaves the array.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
        end else if (rd_adv) begin
            rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (s_data),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

    if (OUTPUT_REG != 0) begin : g_out_reg
        // The head lives in out_q; the array holds the remaining count-1 entries.
        logic [DATA_WIDTH-1:0] out_q;
        logic                  stor_has;
        logic                  bypass;

        assign stor_has = (count > LW'(1));
        // Head slot is (or is about to become) empty and nothing waits in the array.
        assign bypass   = wr_fire && ((count == '0) || ((count == LW'(1)) && rd_fire));
        assign mem_we   = wr_fire && !bypass && !flush && !rst;
        assign rd_adv   = rd_fire && stor_has && !flush && !rst;
        assign m_data   = out_q;

        // Output register: load from the input on bypass, reload from the array on read.
        // The array read slot cannot equal the write slot here: the array is non-empty
        // and can hold at most FIFO_DEPTH-1 entries while the head register is full.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= '0;
            end else if (!flush) begin
                if (bypass) begin
                    out_q <= s_data;
                end else if (rd_fire && stor_has) begin
                    out_q <= mem_rd_data;
                end
            end
        end
    end else begin : g_out_comb
        // Head read straight from the array. rd_ptr equals wr_ptr only when empty
        // (m_valid low) or full (write refused), so the head slot is never being written.
        assign mem_we = wr_fire && !flush && !rst;
        assign rd_adv = rd_fire && !flush && !rst;
        assign m_data = mem_rd_data;
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: DEPTH=4 combinational-output and DEPTH=5 registered-output instances.
// Latency: n/a.
// Backpressure: driven by directed steps and random s_valid/m_ready.
module tb_stream_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, chk_on;
    int   n_chk = 0;
    int   n_fail = 0;

    // Instance a: DEPTH=4, OUTPUT_REG=0, AFULL=3, AEMPTY=1
    logic       a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready;
    logic       a_afull, a_aempty, a_ovf, a_ovf_clr;
    logic [7:0] a_s_data, a_m_data;
    logic [2:0] a_level;

    // Instance b: DEPTH=5, OUTPUT_REG=1, default thresholds (AFULL=4, AEMPTY=1)
    logic       b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic       b_afull, b_aempty, b_ovf, b_ovf_clr;
    logic [7:0] b_s_data, b_m_data;
    logic [2:0] b_level;

    stream_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .OUTPUT_REG(0), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush), .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready), .level(a_level),
        .almost_full(a_afull), .almost_empty(a_aempty), .ovf(a_ovf), .ovf_clr(a_ovf_clr)
    );

    stream_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .OUTPUT_REG(1)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush), .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .level(b_level),
        .almost_full(b_afull), .almost_empty(b_aempty), .ovf(b_ovf), .ovf_clr(b_ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference models: level, ovf and a queue of expected payloads per instance.
    logic [7:0] a_q[$];
    logic [7:0] b_q[$];
    int   a_lvl = 0, b_lvl = 0, b_maxlvl = 0, b_rx = 0;
    bit   a_ovf_m = 0, b_ovf_m = 0, a_wr, a_rd, b_wr, b_rd, b_wr_last = 0;
    bit   af_exp[5] = '{0, 0, 0, 1, 1};
    bit   ae_exp[5] = '{1, 1, 0, 0, 0};

    // Check a against the model mid-cycle, then apply the transfers of the coming edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_level", a_level, a_lvl);
            chk("a_s_ready", a_s_ready, a_lvl != 4);
            chk("a_m_valid", a_m_valid, a_lvl != 0);
            chk("a_afull", a_afull, a_lvl >= 3);
            chk("a_aempty", a_aempty, a_lvl <= 1);
            chk("a_ovf", a_ovf, a_ovf_m);
            if (a_lvl != 0) chk("a_data", a_m_data, a_q[0]);
            if (rst) begin
                a_q.delete(); a_lvl = 0; a_ovf_m = 0;
            end else begin
                a_wr = a_s_valid && (a_lvl != 4);
                a_rd = a_m_ready && (a_lvl != 0);
                if (a_s_valid && a_lvl == 4) a_ovf_m = 1;
                else if (a_ovf_clr) a_ovf_m = 0;
                if (a_flush) begin
                    a_q.delete(); a_lvl = 0;
                end else begin
                    if (a_rd) void'(a_q.pop_front());
                    if (a_wr) a_q.push_back(a_s_data);
                    a_lvl = a_lvl + int'(a_wr) - int'(a_rd);
                end
            end
        end
    end

    // Same for b (depth 5, default thresholds).
    always @(negedge clk) begin
        if (chk_on) begin
            chk("b_level", b_level, b_lvl);
            chk("b_s_ready", b_s_ready, b_lvl != 5);
            chk("b_m_valid", b_m_valid, b_lvl != 0);
            chk("b_afull", b_afull, b_lvl >= 4);
            chk("b_aempty", b_aempty, b_lvl <= 1);
            chk("b_ovf", b_ovf, b_ovf_m);
            if (b_lvl != 0) chk("b_data", b_m_data, b_q[0]);
            if (int'(b_level) > b_maxlvl) b_maxlvl = int'(b_level);
            if (rst) begin
                b_q.delete(); b_lvl = 0; b_ovf_m = 0; b_wr_last = 0;
            end else begin
                b_wr = b_s_valid && (b_lvl != 5);
                b_rd = b_m_ready && (b_lvl != 0);
                if (b_s_valid && b_lvl == 5) b_ovf_m = 1;
                else if (b_ovf_clr) b_ovf_m = 0;
                if (b_flush) begin
                    b_q.delete(); b_lvl = 0; b_wr_last = 0;
                end else begin
                    if (b_rd) begin void'(b_q.pop_front()); b_rx++; end
                    if (b_wr) b_q.push_back(b_s_data);
                    b_lvl = b_lvl + int'(b_wr) - int'(b_rd);
                    b_wr_last = b_wr;
                end
            end
        end
    end

    int b_idx, cyc;

    initial begin
        chk_on = 0; rst = 1;
        a_flush = 0; a_s_valid = 0; a_s_data = 0; a_m_ready = 0; a_ovf_clr = 0;
        b_flush = 0; b_s_valid = 0; b_s_data = 0; b_m_ready = 0; b_ovf_clr = 0;
        tick(); tick();
        rst = 0; chk_on = 1;

        // Reset values
        chk("rst_a_level", a_level, 0);
        chk("rst_a_m_valid", a_m_valid, 0);
        chk("rst_a_s_ready", a_s_ready, 1);
        chk("rst_a_aempty", a_aempty, 1);
        chk("rst_a_afull", a_afull, 0);
        chk("rst_a_ovf", a_ovf, 0);
        chk("rst_b_m_data", b_m_data, 0);

        // Fill A1..A4, overflow attempt, drain in order
        for (int i = 0; i < 4; i++) begin
            a_s_valid = 1; a_s_data = 8'(8'hA1 + i);
            tick();
            chk("fill_level", a_level, i + 1);
        end
        chk("full_s_ready", a_s_ready, 0);
        a_s_data = 8'hA5;
        tick();
        a_s_valid = 0;
        chk("ovf_set", a_ovf, 1);
        chk("ovf_level", a_level, 4);
        a_m_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", a_m_data, 8'(8'hA1 + i));
            chk("drain_aempty", a_aempty, (4 - i) <= 1);
            tick();
        end
        a_m_ready = 0;
        chk("drain_level", a_level, 0);
        a_ovf_clr = 1; tick(); a_ovf_clr = 0;
        chk("ovf_clr", a_ovf, 0);

        // Full: simultaneous read and write -> read only, write rejected
        for (int i = 0; i < 4; i++) begin
            a_s_valid = 1; a_s_data = 8'(8'h10 + i); tick();
        end
        a_s_data = 8'h20; a_m_ready = 1;
        tick();
        chk("full_rw_level", a_level, 3);
        chk("full_rw_ovf", a_ovf, 1);
        chk("full_rw_s_ready", a_s_ready, 1);
        a_m_ready = 0;
        tick();
        a_s_valid = 0;
        chk("full_rw_retry", a_level, 4);
        a_m_ready = 1; tick(); tick(); a_m_ready = 0;

        // Flush at level 2 together with a write of 0x55
        chk("pre_flush_level", a_level, 2);
        a_flush = 1; a_s_valid = 1; a_s_data = 8'h55;
        tick();
        a_flush = 0; a_s_valid = 0;
        chk("flush_level", a_level, 0);
        chk("flush_m_valid", a_m_valid, 0);
        chk("flush_ovf_kept", a_ovf, 1);
        a_s_valid = 1; a_s_data = 8'h66; tick(); a_s_valid = 0;
        chk("post_flush_level", a_level, 1);
        chk("post_flush_data", a_m_data, 8'h66);
        a_m_ready = 1; tick(); a_m_ready = 0;
        a_ovf_clr = 1; tick(); a_ovf_clr = 0;

        // Threshold sweep 0 -> 4 -> 0
        for (int l = 0; l <= 4; l++) begin
            chk("sweep_up_level", a_level, l);
            chk("sweep_up_afull", a_afull, af_exp[l]);
            chk("sweep_up_aempty", a_aempty, ae_exp[l]);
            if (l < 4) begin
                a_s_valid = 1; a_s_data = 8'(8'hC0 + l); tick(); a_s_valid = 0;
            end
        end
        a_s_valid = 1; a_ovf_clr = 1; tick();
        chk("ovf_set_beats_clr", a_ovf, 1);
        a_s_valid = 0; tick(); a_ovf_clr = 0;
        chk("ovf_clr_pulse", a_ovf, 0);
        a_m_ready = 1;
        for (int l = 3; l >= 0; l--) begin
            tick();
            chk("sweep_dn_level", a_level, l);
            chk("sweep_dn_afull", a_afull, af_exp[l]);
            chk("sweep_dn_aempty", a_aempty, ae_exp[l]);
        end
        a_m_ready = 0;

        // Depth-5 registered-output stream with random handshakes
        b_idx = 0; cyc = 0;
        while ((b_idx < 20 || b_lvl != 0) && cyc < 2000) begin
            b_s_valid = (b_idx < 20) && ($urandom_range(0, 3) != 0);
            b_s_data  = 8'(b_idx);
            b_m_ready = ($urandom_range(0, 1) != 0);
            tick();
            if (b_wr_last) b_idx++;
            cyc++;
        end
        b_s_valid = 0; b_m_ready = 0;
        chk("stream_done", (b_idx == 20) && (b_lvl == 0), 1);
        chk("stream_rx_count", b_rx, 20);
        chk("stream_max_level", b_maxlvl <= 5, 1);

        // Reset at level 3, then write 0x7E in both modes
        for (int i = 0; i < 3; i++) begin
            a_s_valid = 1; a_s_data = 8'(8'h30 + i);
            b_s_valid = 1; b_s_data = 8'(8'h40 + i);
            tick();
        end
        a_s_valid = 0; b_s_valid = 0;
        chk("pre_rst_a_level", a_level, 3);
        chk("pre_rst_b_level", b_level, 3);
        rst = 1; tick(); rst = 0;
        chk("rst2_a_level", a_level, 0);
        chk("rst2_a_m_valid", a_m_valid, 0);
        chk("rst2_a_s_ready", a_s_ready, 1);
        chk("rst2_b_level", b_level, 0);
        chk("rst2_b_m_valid", b_m_valid, 0);
        chk("rst2_b_aempty", b_aempty, 1);
        chk("rst2_b_m_data", b_m_data, 0);
        a_s_valid = 1; a_s_data = 8'h7E; b_s_valid = 1; b_s_data = 8'h7E;
        tick();
        a_s_valid = 0; b_s_valid = 0;
        chk("rst_wr_a_valid", a_m_valid, 1);
        chk("rst_wr_a_data", a_m_data, 8'h7E);
        chk("rst_wr_b_valid", b_m_valid, 1);
        chk("rst_wr_b_data", b_m_data, 8'h7E);
        a_m_ready = 1; b_m_ready = 1; tick(); a_m_ready = 0; b_m_ready = 0;
        tick();
        chk("end_a_level", a_level, 0);
        chk("end_b_level", b_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Single-clock, parametrised FIFO with valid/ready streaming ports, first-word-fall-through output, optional registered output stage, programmable almost-full/almost-empty flags, synchronous flush and a sticky overflow flag. Drop-in successor for the plain wr/rd FIFO in the JTAG-to-SPI datapath: buffers command and data bytes between the JTAG shift logic and the SPI engine. Supports any depth ≥ 2, not only powers of two, and reports a full-range fill level.

## Interface

- DATA_WIDTH, 8: payload width in bits.
- FIFO_DEPTH, 32: capacity in entries, ≥ 2, any integer.
- OUTPUT_REG, 0: 0 = m_data read combinationally from storage; 1 = m_data driven from a flop.
- AFULL_LEVEL, FIFO_DEPTH-1: almost_full asserts when level ≥ this value.
- AEMPTY_LEVEL, 1: almost_empty asserts when level ≤ this value.
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- flush  in  1  synchronous content clear.
- s_data  in  DATA_WIDTH  write payload.
- s_valid  in  1  write request.
- s_ready  out  1  space available, equal to (level != FIFO_DEPTH).
- m_data  out  DATA_WIDTH  head-of-queue payload.
- m_valid  out  1  head entry present.
- m_ready  in  1  consumer accepts head.
- level  out  LW=$clog2(FIFO_DEPTH+1)  entries held, 0..FIFO_DEPTH inclusive.
- almost_full / almost_empty  out  1 each  threshold flags.
- ovf  out  1  sticky: a write was attempted while full.
- ovf_clr  in  1  clears ovf.

## Operation

- Write accepted when s_valid && s_ready. Read accepted when m_valid && m_ready.
- s_ready does not depend on m_ready. When full, a write is rejected even if a read occurs in the same cycle.
- Accepted write and read in the same cycle: level unchanged, and both transfers take effect.
- Order is strict FIFO with no loss or duplication.
- Pointers wrap from FIFO_DEPTH-1 to 0 using an explicit compare, so non-power-of-two depths work.
- level is an up/down counter. It is not derived from pointer difference.
- m_data holds stable while m_valid && !m_ready. The OUTPUT_REG=0 implementation must not read from a slot being written in the same cycle.
- OUTPUT_REG=1:
  - Capacity is still exactly FIFO_DEPTH, and level counts the entry held in the output register.
  - A write into an empty FIFO loads the output register directly (bypass).
  - On a read, the output register reloads from storage in the same edge.
- flush:
  - level, pointers and m_valid go to 0 on the next edge.
  - Any transfer accepted in that cycle is discarded.
  - ovf is unaffected.
- ovf:
  - Set on any cycle with s_valid && !s_ready outside reset.
  - Cleared by rst or ovf_clr. Set has priority over ovf_clr in the same cycle.
- rst has priority over flush and all transfers. Memory contents are not reset.
- Reset values after the rst edge: level 0, m_valid 0, s_ready 1, almost_empty 1 (AEMPTY_LEVEL ≥ 0), almost_full 0 (AFULL_LEVEL > 0), ovf 0, m_data 0 (OUTPUT_REG=1) or don't-care (OUTPUT_REG=0).
- While rst is high, s_valid is ignored and does not set ovf.

## Timing

- Write-to-read latency: a write accepted at edge N makes m_valid=1 with that data after edge N, in both modes. This means one cycle latency.
- level, s_ready, almost_full and almost_empty reflect all transfers up to and including the last edge. They are combinational from registered state with no extra lag.
- Full throughput: one write and one read per cycle sustained at any level 1..FIFO_DEPTH-1.
- Full-cycle behaviour: at level=FIFO_DEPTH with a read accepted at edge N, s_ready=1 after edge N.
- flush asserted at edge N: level=0 after N, and a write at N+1 is accepted normally.

## Structure

- Package fifo_pkg holds the function fifo_lw(depth) returning $clog2(depth+1), shared with other FIFOs in the design. No typedefs.
- One sub-module, fifo_mem: simple dual-port array with synchronous write and asynchronous read, parameters DATA_WIDTH and FIFO_DEPTH.
- Pointer, level, flag and output-register logic live in stream_fifo.

## Test plan

- Parameters DEPTH=4, OUTPUT_REG=0. After reset, write 0xA1..0xA4 with m_ready=0: level 1,2,3,4 and s_ready=0 after the 4th write. A 5th s_valid sets ovf=1 and level stays 4. Then drain: data A1,A2,A3,A4 in order, and almost_empty=1 at level ≤1.
- Parameters DEPTH=5 (non-power-of-two), OUTPUT_REG=1. Stream 20 incrementing bytes with random s_valid/m_ready: output is 0x00..0x13 in order, level never exceeds 5, and pointers wrap at index 4.
- Parameters DEPTH=4, level=4. Assert s_valid and m_ready together: read accepted, write rejected, level=3, ovf=1. On the next cycle the write is accepted and level=4.
- Level=2. Assert flush together with a write of 0x55: level=0 and m_valid=0 after the edge. 0x55 never appears at the output, and ovf keeps its previous value.
- Level=3. Assert rst for one cycle: all outputs take their reset values. A subsequent write of 0x7E appears on m_data one cycle later, in both OUTPUT_REG settings.
- Parameters AFULL_LEVEL=3, AEMPTY_LEVEL=1, DEPTH=4. Sweep level 0→4→0: almost_full=1 exactly at levels 3..4 and almost_empty=1 exactly at levels 0..1. Pulse ovf_clr: ovf goes to 0.
